// File: rtl/reg_dump_scanner_pkg.sv
// -----------------------------------------------------------------------------
// reg_dump_scanner_pkg
//   Shared definitions for the register-dump scanner and anything that decodes
//   its debug state (e.g. the UART/LED formatter downstream).
//
//   scan_state_t encodings are fixed so that a sink can decode the exported
//   state directly:
//     IDLE = 2'd0   no scan in progress
//     WAIT = 2'd1   reg_addr driven, waiting for reg_data to settle
//     SEND = 2'd2   sample word presented on the output stream
//
//   cnt_width(n) returns the width needed to hold the values 0..n-1
//   (minimum 1 bit), used for the settle and period counters.
// -----------------------------------------------------------------------------
package reg_dump_scanner_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } scan_state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_dump_scanner_period_timer.sv
// -----------------------------------------------------------------------------
// scan_period_timer
//   Idle-time counter that requests an automatic scan. The count advances only
//   while 'run' is high, is cleared whenever a scan starts, and 'expire' is
//   raised combinationally in the cycle the count sits at AUTO_PERIOD-1.
//   With AUTO_PERIOD == 0 the counter is held at zero and 'expire' never fires.
//
// Ports
//   clk     in  1  system clock
//   rst     in  1  asynchronous active-low reset
//   run     in  1  count enable (scanner is idle)
//   clear   in  1  synchronous clear (a scan is starting)
//   expire  out 1  auto-start request
// -----------------------------------------------------------------------------
module scan_period_timer
    import reg_dump_scanner_pkg::*;
#(
    parameter int AUTO_PERIOD = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam bit ENABLED = (AUTO_PERIOD > 0);
    localparam int CNT_W   = cnt_width(AUTO_PERIOD);
    localparam logic [CNT_W-1:0] LAST = CNT_W'((AUTO_PERIOD > 0) ? AUTO_PERIOD - 1 : 0);

    logic [CNT_W-1:0] count;

    assign expire = ENABLED && run && (count == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || !ENABLED) begin
            count <= '0;
        end else if (run && !expire) begin
            // Holding at LAST keeps the request up if the scanner cannot
            // start in the expiring cycle for any reason.
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/reg_dump_scanner.sv
// -----------------------------------------------------------------------------
// reg_dump_scanner
//   Debug read-out stage behind processor_top's register-file tap. A scan walks
//   reg_addr through 0..NUM_REGS-1, waits READ_LAT cycles for reg_data to
//   settle after each address change, and emits {addr, data} on a valid/ready
//   stream. Scans start on a 'start' pulse while idle or, when AUTO_PERIOD is
//   non-zero, AUTO_PERIOD cycles after the previous scan completed.
//
// Ports
//   clk        in   1              system clock, rising edge
//   rst        in   1              asynchronous active-low reset
//   start      in   1              scan request, dropped while busy
//   reg_addr   out  ADDR_W         to processor_top.reg_addr
//   reg_data   in   DATA_W         from processor_top.reg_data_output
//   out_data   out  ADDR_W+DATA_W  {addr, data} sample word
//   out_valid  out  1              out_data valid
//   out_ready  in   1              sink ready
//   busy       out  1              scan in progress
//   done       out  1              one-cycle pulse after the last word is taken
//   dbg_state  out  scan_state_t   current FSM state
//
// Stream handshake: a word transfers on a rising edge where out_valid and
// out_ready are both high. Once out_valid is raised, out_data and out_valid
// stay unchanged until that transfer; out_valid never depends on out_ready.
// -----------------------------------------------------------------------------
module reg_dump_scanner
    import reg_dump_scanner_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 4,
    parameter int NUM_REGS    = 16,
    parameter int READ_LAT    = 1,
    parameter int AUTO_PERIOD = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [ADDR_W-1:0]          reg_addr,
    input  logic [DATA_W-1:0]          reg_data,
    output logic [ADDR_W+DATA_W-1:0]   out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       done,
    output scan_state_t                dbg_state
);

    localparam int LAT_W = cnt_width(READ_LAT);
    localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(READ_LAT - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    scan_state_t                 state, state_nx;
    logic [LAT_W-1:0]            lat_cnt, lat_cnt_nx;
    logic [ADDR_W-1:0]           addr_nx;
    logic [ADDR_W+DATA_W-1:0]    data_nx;
    logic                        valid_nx;
    logic                        busy_nx;
    logic                        done_nx;

    logic                        timer_run;
    logic                        auto_fire;
    logic                        scan_go;

    // Without an auto period the timer is tied off and never counts.
    assign timer_run = (AUTO_PERIOD != 0) && (state == IDLE);

    scan_period_timer #(
        .AUTO_PERIOD (AUTO_PERIOD)
    ) u_period_timer (
        .clk    (clk),
        .rst    (rst),
        .run    (timer_run),
        .clear  (scan_go),
        .expire (auto_fire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            reg_addr  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            lat_cnt   <= lat_cnt_nx;
            reg_addr  <= addr_nx;
            out_data  <= data_nx;
            out_valid <= valid_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        lat_cnt_nx = lat_cnt;
        addr_nx    = reg_addr;
        data_nx    = out_data;
        valid_nx   = out_valid;
        busy_nx    = busy;
        done_nx    = 1'b0;
        scan_go    = 1'b0;

        case (state)
            IDLE: begin
                // reg_addr keeps its last value while idle.
                if (start || auto_fire) begin
                    scan_go    = 1'b1;
                    state_nx   = WAIT;
                    addr_nx    = '0;
                    busy_nx    = 1'b1;
                    lat_cnt_nx = LAT_INIT;
                end
            end

            WAIT: begin
                if (lat_cnt == '0) begin
                    data_nx  = {reg_addr, reg_data};
                    valid_nx = 1'b1;
                    state_nx = SEND;
                end else begin
                    lat_cnt_nx = lat_cnt - LAT_W'(1);
                end
            end

            SEND: begin
                // reg_addr is frozen here, so a stalled word always matches
                // the address still being driven to the register file.
                if (out_valid && out_ready) begin
                    valid_nx = 1'b0;
                    if (reg_addr == LAST_ADDR) begin
                        state_nx = IDLE;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                    end else begin
                        addr_nx    = reg_addr + ADDR_W'(1);
                        lat_cnt_nx = LAT_INIT;
                        state_nx   = WAIT;
                    end
                end
            end

            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
                valid_nx = 1'b0;
            end
        endcase
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_reg_dump_scanner.sv
module tb_reg_dump_scanner;
  import reg_dump_scanner_pkg::*;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int OW = AW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  logic rst_c = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b1;
  logic use_rand = 1'b1;
  logic [DW-1:0] rnd_data = '0;

  logic [AW-1:0] reg_addr_a, reg_addr_b, reg_addr_c;
  logic [DW-1:0] reg_data_a, reg_data_b, reg_data_c;
  logic [OW-1:0] out_data_a, out_data_b, out_data_c;
  logic out_valid_a, out_valid_b, out_valid_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;
  scan_state_t state_a, state_b, state_c;

  // ---------------- register-file models ----------------
  assign reg_data_a = use_rand ? rnd_data : (16'hA000 | {12'h000, reg_addr_a});
  assign reg_data_c = 16'hC000 | {12'h000, reg_addr_c};

  // Slow register file: X until the address has been stable for 2 cycles,
  // i.e. valid exactly at the third edge after a change.
  int age_b = 0;
  logic [AW-1:0] last_addr_b = '0;
  logic busy_b_q = 1'b0;
  always @(posedge clk) begin
    #1;
    if (reg_addr_b !== last_addr_b || (busy_b && !busy_b_q)) age_b = 0;
    else age_b = age_b + 1;
    last_addr_b = reg_addr_b;
    busy_b_q = busy_b;
  end
  assign reg_data_b = (age_b >= 2) ? (16'hB000 | {12'h000, reg_addr_b}) : 16'hxxxx;

  // ---------------- DUTs ----------------
  reg_dump_scanner #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(16), .READ_LAT(1), .AUTO_PERIOD(0)) u_dut_a (
    .clk(clk), .rst(rst_a), .start(start), .reg_addr(reg_addr_a), .reg_data(reg_data_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .busy(busy_a), .done(done_a), .dbg_state(state_a));

  reg_dump_scanner #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(16), .READ_LAT(3), .AUTO_PERIOD(0)) u_dut_b (
    .clk(clk), .rst(rst_b), .start(start), .reg_addr(reg_addr_b), .reg_data(reg_data_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .busy(busy_b), .done(done_b), .dbg_state(state_b));

  reg_dump_scanner #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(16), .READ_LAT(1), .AUTO_PERIOD(10)) u_dut_c (
    .clk(clk), .rst(rst_c), .start(start), .reg_addr(reg_addr_c), .reg_data(reg_data_c),
    .out_data(out_data_c), .out_valid(out_valid_c), .out_ready(out_ready),
    .busy(busy_c), .done(done_c), .dbg_state(state_c));

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_words = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int hs_first = -1;
  int hs_last = -1;

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic take_word(input logic [OW-1:0] w);
    n_words++;
    if (hs_first < 0) hs_first = cyc;
    hs_last = cyc;
    check("sb_word_expected", OW'(exp_q.size() != 0), OW'(1));
    if (exp_q.size() != 0) check("sb_word", w, exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (rst_a && out_valid_a && out_ready) take_word(out_data_a);
    if (rst_b && out_valid_b && out_ready) take_word(out_data_b);
    if (rst_c && out_valid_c && out_ready) take_word(out_data_c);
    if (done_a || done_b || done_c) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_scan(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({AW'(i), base | DW'(i)});
  endtask

  task automatic start_pulse(output int t0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    for (int k = 0; k < budget && done_cnt < target; k++) begin
      @(posedge clk); #1;
    end
    check(tag, OW'(done_cnt), OW'(target));
  endtask

  task automatic wait_word_a(input logic [AW-1:0] a, input int budget, input string tag);
    for (int k = 0; k < budget && !(out_valid_a && reg_addr_a == a); k++) begin
      @(posedge clk); #1;
    end
    check(tag, {15'b0, out_valid_a, reg_addr_a}, {15'b0, 1'b1, a});
  endtask

  // ---------------- directed sequence ----------------
  int t0, d, w0, r, dc1;

  initial begin
    // 1: reset with start held and random register data
    start = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      rnd_data = DW'($urandom_range(0, 16'hFFFF));
    end
    check("rst_reg_addr", OW'(reg_addr_a), OW'(0));
    check("rst_out_data", out_data_a, OW'(0));
    check("rst_out_valid", OW'(out_valid_a), OW'(0));
    check("rst_busy", OW'(busy_a), OW'(0));
    check("rst_done", OW'(done_a), OW'(0));
    check("rst_state", OW'(state_a), OW'(IDLE));
    start = 1'b0;
    use_rand = 1'b0;
    rst_a = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_busy", OW'(busy_a), OW'(0));
    check("post_rst_state", OW'(state_a), OW'(IDLE));
    check("post_rst_words", OW'(n_words), OW'(0));

    // 2: basic scan, READ_LAT=1, ready held high
    hs_first = -1;
    w0 = n_words;
    d = done_cnt;
    push_scan(16'hA000, 16);
    start_pulse(t0);
    wait_done(d + 1, 100, "basic_done_seen");
    check("basic_first_valid", OW'(hs_first - t0), OW'(1));
    check("basic_word_span", OW'(hs_last - hs_first), OW'(30));
    check("basic_done_time", OW'(done_cyc - t0), OW'(32));
    check("basic_words", OW'(n_words - w0), OW'(16));
    check("basic_queue_empty", OW'(exp_q.size()), OW'(0));
    check("basic_idle_addr", OW'(reg_addr_a), OW'(15));
    @(posedge clk); #1;
    check("basic_done_width", OW'(done_a), OW'(0));
    check("basic_busy_after", OW'(busy_a), OW'(0));

    // 3: back-pressure on word 3
    hs_first = -1;
    w0 = n_words;
    d = done_cnt;
    push_scan(16'hA000, 16);
    start_pulse(t0);
    wait_word_a(4'd3, 50, "bp_reach_w3");
    out_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_hold_data", out_data_a, 20'h3A003);
      check("bp_hold_addr", OW'(reg_addr_a), OW'(3));
      check("bp_hold_valid", OW'(out_valid_a), OW'(1));
    end
    out_ready = 1'b1;
    wait_done(d + 1, 100, "bp_done_seen");
    check("bp_done_time", OW'(done_cyc - t0), OW'(37));
    check("bp_words", OW'(n_words - w0), OW'(16));
    check("bp_queue_empty", OW'(exp_q.size()), OW'(0));

    // 5: start collisions mid-scan and on the final handshake edge
    w0 = n_words;
    d = done_cnt;
    push_scan(16'hA000, 16);
    start_pulse(t0);
    wait_word_a(4'd5, 50, "coll_reach_w5");
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_word_a(4'd15, 100, "coll_reach_w15");
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("coll_done_now", OW'(done_a), OW'(1));
    repeat (15) @(posedge clk);
    #1;
    check("coll_one_done", OW'(done_cnt - d), OW'(1));
    check("coll_busy", OW'(busy_a), OW'(0));
    check("coll_state", OW'(state_a), OW'(IDLE));
    check("coll_words", OW'(n_words - w0), OW'(16));
    check("coll_queue_empty", OW'(exp_q.size()), OW'(0));

    // 6a: reset mid-scan at word 7
    d = done_cnt;
    push_scan(16'hA000, 7);
    start_pulse(t0);
    wait_word_a(4'd7, 50, "abort_reach_w7");
    rst_a = 1'b0;
    #1;
    check("abort_out_data", out_data_a, OW'(0));
    check("abort_out_valid", OW'(out_valid_a), OW'(0));
    check("abort_busy", OW'(busy_a), OW'(0));
    check("abort_reg_addr", OW'(reg_addr_a), OW'(0));
    check("abort_state", OW'(state_a), OW'(IDLE));
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", OW'(done_cnt - d), OW'(0));
    check("abort_queue_empty", OW'(exp_q.size()), OW'(0));

    // 4: settle time, READ_LAT=3 with an X-until-stable register file
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    hs_first = -1;
    w0 = n_words;
    d = done_cnt;
    push_scan(16'hB000, 16);
    start_pulse(t0);
    wait_done(d + 1, 200, "settle_done_seen");
    check("settle_first_valid", OW'(hs_first - t0), OW'(3));
    check("settle_word_span", OW'(hs_last - hs_first), OW'(60));
    check("settle_done_time", OW'(done_cyc - t0), OW'(64));
    check("settle_words", OW'(n_words - w0), OW'(16));
    check("settle_queue_empty", OW'(exp_q.size()), OW'(0));
    rst_b = 1'b0;

    // 6b: auto mode, AUTO_PERIOD=10, no start pulses
    @(posedge clk); #1;
    rst_c = 1'b1;
    r = cyc;
    hs_first = -1;
    w0 = n_words;
    d = done_cnt;
    push_scan(16'hC000, 16);
    push_scan(16'hC000, 16);
    wait_done(d + 1, 200, "auto_done1_seen");
    dc1 = done_cyc;
    check("auto_first_valid", OW'(hs_first - r), OW'(11));
    hs_first = -1;
    wait_done(d + 2, 200, "auto_done2_seen");
    check("auto_restart_valid", OW'(hs_first - dc1), OW'(11));
    check("auto_done_spacing", OW'(done_cyc - dc1), OW'(42));
    check("auto_words", OW'(n_words - w0), OW'(32));
    check("auto_queue_empty", OW'(exp_q.size()), OW'(0));
    rst_c = 1'b0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
